// File: rtl/secure_arb_pkg.sv
// Shared parameters, slot encoding and request-buffer layout for the
// two-domain time-division register arbiter.
package secure_arb_pkg;
    localparam int DW   = 16;
    localparam int AW   = 2;
    localparam int NENT = 1 << AW;

    localparam logic SLOT_L = 1'b0;
    localparam logic SLOT_H = 1'b1;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] idx;
        logic [DW-1:0] wdata;
    } req_t;
endpackage

// File: rtl/secure_array_arbiter_if.sv
// Request/response handshake bundle for one security domain.
interface secure_array_arbiter_if;
    import secure_arb_pkg::*;

    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_idx;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;

    modport master (
        output req_valid, req_we, req_idx, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_idx, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/arb_domain_port.sv
// One domain's request buffer, private bank and response registers.
// Everything in here is labelled with the owning domain; only slot/reset are shared.
module arb_domain_port
    import secure_arb_pkg::*;
#(
    parameter logic OWN_SLOT = SLOT_L
) (
    input  logic clk,
    input  logic reset,
    input  logic slot,
    secure_array_arbiter_if.slave bus
);
    req_t          req_buf_reg;
    logic          buf_valid_reg;
    logic [DW-1:0] bank_reg [NENT];
    logic          rsp_valid_reg;
    logic [DW-1:0] rsp_rdata_reg;

    logic my_slot;
    logic service;
    logic accept;

    assign my_slot = (slot == OWN_SLOT);
    assign service = buf_valid_reg && my_slot;
    // The buffer is free either when empty or when it drains this cycle.
    assign bus.req_ready = reset || !buf_valid_reg || my_slot;
    assign accept        = bus.req_valid && bus.req_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            buf_valid_reg <= 1'b0;
            req_buf_reg   <= '0;
        end else if (accept) begin
            buf_valid_reg <= 1'b1;
            req_buf_reg   <= '{we: bus.req_we, idx: bus.req_idx, wdata: bus.req_wdata};
        end else if (service) begin
            buf_valid_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NENT; i++) begin
            if (reset) begin
                bank_reg[i] <= '0;
            end else if (service && req_buf_reg.we && (req_buf_reg.idx == AW'(i))) begin
                bank_reg[i] <= req_buf_reg.wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid_reg <= 1'b0;
            rsp_rdata_reg <= '0;
        end else begin
            rsp_valid_reg <= service;
            rsp_rdata_reg <= (service && !req_buf_reg.we) ? bank_reg[req_buf_reg.idx] : '0;
        end
    end

    assign bus.rsp_valid = rsp_valid_reg;
    assign bus.rsp_rdata = rsp_rdata_reg;
endmodule

// File: rtl/secure_array_arbiter.sv
// Fixed TDM arbiter: slot alternates L/H every cycle regardless of demand,
// so H traffic cannot influence anything the L domain observes.
module secure_array_arbiter
    import secure_arb_pkg::*;
(
    input  logic clk,
    input  logic reset,
    output logic slot,
    secure_array_arbiter_if.slave l_port,
    secure_array_arbiter_if.slave h_port
);
    logic slot_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            slot_reg <= SLOT_L;
        end else begin
            slot_reg <= ~slot_reg;
        end
    end

    assign slot = slot_reg;

    arb_domain_port #(.OWN_SLOT(SLOT_L)) u_l_port (
        .clk   (clk),
        .reset (reset),
        .slot  (slot_reg),
        .bus   (l_port)
    );

    arb_domain_port #(.OWN_SLOT(SLOT_H)) u_h_port (
        .clk   (clk),
        .reset (reset),
        .slot  (slot_reg),
        .bus   (h_port)
    );
endmodule
